// File: rtl/wb_na_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_na_mem_bridge
// Purpose  : Registered Wishbone bridge from the tile network adapter master
//            port to the tile data-memory RAM slave. One register stage in
//            each direction. Out-of-window accesses get a bus error. Hung
//            slave transfers are aborted with a timeout error. Saturating
//            error counters are kept for debug.
// Ports    : clk, rst (sync, active-low)
//            m_*  : upstream Wishbone slave side (from the NA master)
//            s_*  : downstream Wishbone master side (to the RAM)
//            range_err_cnt_o / timeout_cnt_o : saturating error counters
//            busy_o : high whenever the bridge is not idle
// Revision : 1.0 - initial release
// ============================================================================
module wb_na_mem_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0001_0000,
    parameter int          TIMEOUT   = 255,
    parameter int          CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    // upstream (NA master)
    input  logic [31:0]          m_adr_i,
    input  logic [31:0]          m_dat_i,
    input  logic [3:0]           m_sel_i,
    input  logic                 m_we_i,
    input  logic                 m_cyc_i,
    input  logic                 m_stb_i,
    output logic [31:0]          m_dat_o,
    output logic                 m_ack_o,
    output logic                 m_err_o,
    // downstream (RAM slave)
    output logic [31:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    // debug
    output logic [CNT_WIDTH-1:0] range_err_cnt_o,
    output logic [CNT_WIDTH-1:0] timeout_cnt_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last wait-count value on which the slave may still answer.
    localparam logic [15:0]          TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        resp_pend;   // a slave-side response is waiting to go upstream
    logic        resp_err;
    logic [31:0] resp_dat;

    // Window check done as a 33-bit subtraction: a borrow means the address
    // lies below the base, and the low 32 bits are the window offset.
    logic [32:0] adr_diff;
    logic        in_window;
    logic        req_new;

    assign adr_diff  = {1'b0, m_adr_i} - {1'b0, ADDR_BASE};
    assign in_window = ~adr_diff[32] && (adr_diff[31:0] < ADDR_SIZE);

    // While a response pulse is on the bus the master still shows the request
    // it is being answered for; it must not start a second transfer.
    assign req_new = m_cyc_i & m_stb_i & ~m_ack_o & ~m_err_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            resp_pend       <= 1'b0;
            resp_err        <= 1'b0;
            resp_dat        <= '0;
            m_dat_o         <= '0;
            m_ack_o         <= 1'b0;
            m_err_o         <= 1'b0;
            s_adr_o         <= '0;
            s_dat_o         <= '0;
            s_sel_o         <= '0;
            s_we_o          <= 1'b0;
            s_cyc_o         <= 1'b0;
            s_stb_o         <= 1'b0;
            range_err_cnt_o <= '0;
            timeout_cnt_o   <= '0;
            busy_o          <= 1'b0;
        end else begin
            // Upstream response lines are single-cycle pulses.
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_dat_o <= '0;

            case (state)
                IDLE: begin
                    if (req_new) begin
                        s_adr_o <= adr_diff[31:0];
                        s_dat_o <= m_dat_i;
                        s_sel_o <= m_sel_i;
                        s_we_o  <= m_we_i;
                        busy_o  <= 1'b1;
                        if (in_window) begin
                            s_cyc_o  <= 1'b1;
                            s_stb_o  <= 1'b1;
                            wait_cnt <= '0;
                            state    <= REQ;
                        end else begin
                            // Range error is answered immediately; RESP only
                            // covers the pulse cycle.
                            m_err_o   <= 1'b1;
                            resp_pend <= 1'b0;
                            state     <= RESP;
                            if (range_err_cnt_o != CNT_MAX)
                                range_err_cnt_o <= range_err_cnt_o + CNT_ONE;
                        end
                    end
                end

                REQ: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // Priority: master abort > slave error > slave ack > timeout.
                    if (!m_cyc_i) begin
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else if (s_err_i) begin
                        s_cyc_o   <= 1'b0;
                        s_stb_o   <= 1'b0;
                        resp_pend <= 1'b1;
                        resp_err  <= 1'b1;
                        resp_dat  <= '0;
                        state     <= RESP;
                    end else if (s_ack_i) begin
                        s_cyc_o   <= 1'b0;
                        s_stb_o   <= 1'b0;
                        resp_pend <= 1'b1;
                        resp_err  <= 1'b0;
                        resp_dat  <= s_we_o ? 32'h0 : s_dat_i;
                        state     <= RESP;
                    end else if (wait_cnt == TO_LAST) begin
                        s_cyc_o   <= 1'b0;
                        s_stb_o   <= 1'b0;
                        resp_pend <= 1'b1;
                        resp_err  <= 1'b1;
                        resp_dat  <= '0;
                        state     <= RESP;
                        if (timeout_cnt_o != CNT_MAX)
                            timeout_cnt_o <= timeout_cnt_o + CNT_ONE;
                    end
                end

                RESP: begin
                    if (resp_pend) begin
                        m_ack_o <= ~resp_err;
                        m_err_o <= resp_err;
                        m_dat_o <= resp_err ? 32'h0 : resp_dat;
                    end
                    resp_pend <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    s_cyc_o <= 1'b0;
                    s_stb_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_na_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_na_mem_bridge
// Purpose  : Directed self-checking bench for wb_na_mem_bridge. Two instances:
//            dut_a uses the default window with TIMEOUT=4, dut_b uses a window
//            based at 0x1000_0000. Address/data/slave inputs are shared; each
//            instance has its own cyc/stb so only one is active at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_na_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m_adr = '0;
    logic [31:0] m_dat = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we  = 1'b0;
    logic        cyc_a = 1'b0, stb_a = 1'b0;
    logic        cyc_b = 1'b0, stb_b = 1'b0;
    logic [31:0] s_rdat = '0;
    logic        s_ack  = 1'b0;
    logic        s_err  = 1'b0;

    logic [31:0] a_m_dat, a_s_adr, a_s_dat;
    logic        a_m_ack, a_m_err, a_s_we, a_s_cyc, a_s_stb, a_busy;
    logic [3:0]  a_s_sel;
    logic [7:0]  a_rcnt, a_tcnt;

    logic [31:0] b_m_dat, b_s_adr, b_s_dat;
    logic        b_m_ack, b_m_err, b_s_we, b_s_cyc, b_s_stb, b_busy;
    logic [3:0]  b_s_sel;
    logic [7:0]  b_rcnt, b_tcnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_na_mem_bridge #(.TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(cyc_a), .m_stb_i(stb_a),
        .m_dat_o(a_m_dat), .m_ack_o(a_m_ack), .m_err_o(a_m_err),
        .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel), .s_we_o(a_s_we),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
        .range_err_cnt_o(a_rcnt), .timeout_cnt_o(a_tcnt), .busy_o(a_busy)
    );

    wb_na_mem_bridge #(.ADDR_BASE(32'h1000_0000)) dut_b (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(cyc_b), .m_stb_i(stb_b),
        .m_dat_o(b_m_dat), .m_ack_o(b_m_ack), .m_err_o(b_m_err),
        .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel), .s_we_o(b_s_we),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
        .range_err_cnt_o(b_rcnt), .timeout_cnt_o(b_tcnt), .busy_o(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read on dut_a with the slave acking after k extra stb cycles.
    task automatic do_read_a(input logic [31:0] adr, input logic [31:0] rd, input int k);
        m_adr = adr; m_we = 1'b0; m_sel = 4'hF;
        cyc_a = 1'b1; stb_a = 1'b1;
        tick();
        chk("rd_stb_up", {31'h0, a_s_stb}, 32'h1);
        chk("rd_s_adr",  a_s_adr, adr);
        for (int i = 0; i < k; i++) begin
            tick();
            chk("rd_stb_wait", {31'h0, a_s_stb}, 32'h1);
        end
        s_ack = 1'b1; s_rdat = rd;
        tick();
        s_ack = 1'b0; s_rdat = '0;
        chk("rd_ack_early", {30'h0, a_m_ack, a_s_stb}, 32'h0);
        tick();
        chk("rd_ack_err", {30'h0, a_m_ack, a_m_err}, 32'h2);
        chk("rd_data",    a_m_dat, rd);
        // Request still held while ack is visible: must not be re-accepted.
        tick();
        chk("rd_no_reaccept", {29'h0, a_m_ack, a_s_stb, a_busy}, 32'h0);
        cyc_a = 1'b0; stb_a = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int errs;
        int stbs;
        int resp;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_ctrl", {26'h0, a_m_ack, a_m_err, a_s_cyc, a_s_stb, a_busy, a_s_we}, 32'h0);
        chk("rst_cnt",  {16'h0, a_rcnt, a_tcnt}, 32'h0);
        chk("rst_adr",  a_s_adr, 32'h0);
        rst = 1'b1;
        tick();

        // ---------------- read, k=0 ----------------
        do_read_a(32'h0000_0010, 32'hDEAD_BEEF, 0);

        // ---------------- write on dut_b, k=5 ----------------
        m_adr = 32'h1000_0004; m_dat = 32'h1234_5678; m_sel = 4'b0011; m_we = 1'b1;
        cyc_b = 1'b1; stb_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wr_stb_held", {31'h0, b_s_stb}, 32'h1);
            chk("wr_fields",   {b_s_adr[15:0], 7'h0, b_s_we, 4'h0, b_s_sel}, 32'h0004_0103);
            chk("wr_wdata",    b_s_dat, 32'h1234_5678);
            chk("wr_no_resp",  {30'h0, b_m_ack, b_m_err}, 32'h0);
            if (i == 5) begin
                s_ack = 1'b1; s_rdat = 32'hAAAA_5555;
            end
        end
        tick();
        s_ack = 1'b0; s_rdat = '0;
        chk("wr_stb_drop", {30'h0, b_s_stb, b_m_ack}, 32'h0);
        tick();
        chk("wr_ack",  {30'h0, b_m_ack, b_m_err}, 32'h2);
        chk("wr_mdat", b_m_dat, 32'h0);
        cyc_b = 1'b0; stb_b = 1'b0; m_we = 1'b0;
        tick();
        chk("wr_single_ack", {31'h0, b_m_ack}, 32'h0);

        // ---------------- out-of-window ----------------
        m_adr = 32'h0001_0000; cyc_a = 1'b1; stb_a = 1'b1;
        tick();
        chk("oow_err",  {29'h0, a_m_err, a_m_ack, a_s_stb}, 32'h4);
        chk("oow_cnt1", {24'h0, a_rcnt}, 32'h1);
        tick();
        chk("oow_err_drop", {31'h0, a_m_err}, 32'h0);
        cyc_a = 1'b0; stb_a = 1'b0;
        tick();
        errs = 0; stbs = 0;
        for (int i = 0; i < 299; i++) begin
            cyc_a = 1'b1; stb_a = 1'b1;
            tick();
            if (a_m_err) errs++;
            if (a_s_stb) stbs++;
            tick();
            cyc_a = 1'b0; stb_a = 1'b0;
            tick();
        end
        chk("oow_pulses", errs, 32'd299);
        chk("oow_no_stb", stbs, 32'd0);
        chk("oow_sat",    {24'h0, a_rcnt}, 32'd255);

        // ---------------- timeout, TIMEOUT=4 ----------------
        m_adr = 32'h0000_0020; m_we = 1'b0;
        cyc_a = 1'b1; stb_a = 1'b1;
        errs = 0; stbs = 0; resp = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_s_stb) stbs++;
            if (a_m_ack) resp++;
            if (a_m_err) begin
                errs++;
                cyc_a = 1'b0; stb_a = 1'b0;
            end
        end
        cyc_a = 1'b0; stb_a = 1'b0;
        chk("to_stb_cycles", stbs, 32'd4);
        chk("to_err_pulses", errs, 32'd1);
        chk("to_no_ack",     resp, 32'd0);
        chk("to_cnt",        {24'h0, a_tcnt}, 32'd1);
        do_read_a(32'h0000_0030, 32'hCAFE_F00D, 1);

        // ---------------- ack and err together ----------------
        m_adr = 32'h0000_0040; cyc_a = 1'b1; stb_a = 1'b1;
        tick();
        s_ack = 1'b1; s_err = 1'b1; s_rdat = 32'h5555_AAAA;
        tick();
        s_ack = 1'b0; s_err = 1'b0; s_rdat = '0;
        tick();
        chk("ackerr_resp", {30'h0, a_m_ack, a_m_err}, 32'h1);
        chk("ackerr_mdat", a_m_dat, 32'h0);
        cyc_a = 1'b0; stb_a = 1'b0;
        tick();

        // ---------------- master abort with simultaneous ack ----------------
        m_adr = 32'h0000_0044; cyc_a = 1'b1; stb_a = 1'b1;
        tick();
        cyc_a = 1'b0; stb_a = 1'b0; s_ack = 1'b1; s_rdat = 32'h0BAD_0BAD;
        tick();
        s_ack = 1'b0; s_rdat = '0;
        chk("abort_idle", {29'h0, a_busy, a_s_stb, a_s_cyc}, 32'h0);
        resp = 0;
        for (int i = 0; i < 3; i++) begin
            if (a_m_ack || a_m_err) resp++;
            tick();
        end
        chk("abort_no_resp", resp, 32'd0);

        // ---------------- reset during REQ ----------------
        m_adr = 32'h0000_0050; cyc_a = 1'b1; stb_a = 1'b1;
        tick();
        chk("rstreq_in_req", {30'h0, a_s_stb, a_busy}, 32'h3);
        rst = 1'b0;
        tick();
        chk("rstreq_ctrl", {26'h0, a_m_ack, a_m_err, a_s_cyc, a_s_stb, a_busy, a_s_we}, 32'h0);
        chk("rstreq_cnt",  {16'h0, a_rcnt, a_tcnt}, 32'h0);
        chk("rstreq_adr",  a_s_adr, 32'h0);
        chk("rstreq_mdat", a_m_dat, 32'h0);
        rst = 1'b1; cyc_a = 1'b0; stb_a = 1'b0;
        tick();
        chk("rstreq_no_resp", {30'h0, a_m_ack, a_m_err}, 32'h0);
        do_read_a(32'h0000_0080, 32'h0102_0304, 0);
        do_read_a(32'h0000_FFFC, 32'hF0E1_D2C3, 2);
        chk("final_cnt", {16'h0, a_rcnt, a_tcnt}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
